debounce_click: RTL and testbench

//  Cleans a raw push-button into the "click" stimulus for the 3-bit ripple counter stage.
//  2-FF synchronizer, then a stability counter and a 4-state FSM.

---
 rtl/debounce_click_pkg.sv | 17 +
 rtl/debounce_click_sincronizador.sv | 25 ++
 rtl/debounce_click.sv | 102 ++++++++++
 tb/tb_debounce_click.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/debounce_click_pkg.sv
// Shared definitions for the button debouncer: sync depth, FSM state encoding, polarity helper.
package debounce_click_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  function automatic logic normalise(input logic raw, input bit active_low);
    return active_low ? ~raw : raw;
  endfunction

endpackage

// File: rtl/debounce_click_sincronizador.sv
// Generic multi-flop synchronizer for asynchronous pins; latency STAGES edges, no flow control.
module sincronizador #(
  parameter int               WIDTH     = 1,
  parameter int               STAGES    = debounce_click_pkg::SYNC_STAGES,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stage;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage <= {STAGES{RESET_VAL}};
    end else begin
      stage <= {stage[STAGES-2:0], d};
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/debounce_click.sv
// Push-button debouncer: emits registered click/solto pulses and a debounced level.
// Press or release is accepted DEBOUNCE_CYCLES+2 edges after the pin settles; no flow control.
module debounce_click
  import debounce_click_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic botao,
  output logic click,
  output logic solto,
  output logic nivel
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  generate
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
      $error("debounce_click: DEBOUNCE_CYCLES must be >= 2");
    end
  endgenerate

  logic       raw_sync;
  logic       pressed;
  state_t     state;
  logic [CNT_W-1:0] cnt;

  // Reset value is the raw idle level so a held button is seen as a fresh press.
  sincronizador #(
    .WIDTH    (1),
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'(BTN_ACTIVE_LOW))
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (botao),
    .q    (raw_sync)
  );

  assign pressed = normalise(raw_sync, BTN_ACTIVE_LOW);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      click <= 1'b0;
      solto <= 1'b0;
      nivel <= 1'b0;
    end else begin
      click <= 1'b0;
      solto <= 1'b0;
      case (state)
        IDLE: begin
          if (pressed) begin
            state <= PRESS_WAIT;
            cnt   <= CNT_W'(1);
          end
        end
        PRESS_WAIT: begin
          if (!pressed) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= PRESSED;
            cnt   <= '0;
            click <= 1'b1;
            nivel <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!pressed) begin
            state <= RELEASE_WAIT;
            cnt   <= CNT_W'(1);
          end
        end
        RELEASE_WAIT: begin
          if (pressed) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
            cnt   <= '0;
            solto <= 1'b1;
            nivel <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debounce_click.sv
// Self-checking bench for debounce_click with DEBOUNCE_CYCLES=4, active-low button.
module tb_debounce_click;

  localparam int DC = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic botao = 1'b1;
  logic click, solto, nivel;

  int tests = 0;
  int fails = 0;
  int click_cnt = 0;
  int solto_cnt = 0;

  // Reference: a change is accepted once the last DC synchronised samples all disagree with the level.
  logic m_r1, m_r2, m_niv, m_click, m_solto;
  logic hist[$];

  typedef struct {
    logic b;
    logic r;
    logic c;
    logic s;
    logic n;
  } vec_t;
  vec_t vecs[$];

  debounce_click #(
    .DEBOUNCE_CYCLES(DC),
    .BTN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .botao(botao),
    .click(click),
    .solto(solto),
    .nivel(nivel)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [2:0] got, input logic [2:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: {click,solto,nivel} got %b required %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_r1    = 1'b1;
    m_r2    = 1'b1;
    m_niv   = 1'b0;
    m_click = 1'b0;
    m_solto = 1'b0;
    hist.delete();
  endtask

  task automatic model_edge(input logic b);
    logic p;
    bit   all_diff;
    p    = ~m_r2;
    m_r2 = m_r1;
    m_r1 = b;
    hist.push_back(p);
    if (hist.size() > DC) void'(hist.pop_front());
    m_click  = 1'b0;
    m_solto  = 1'b0;
    all_diff = (hist.size() == DC);
    foreach (hist[i]) if (hist[i] == m_niv) all_diff = 1'b0;
    if (all_diff) begin
      m_niv = ~m_niv;
      if (m_niv) m_click = 1'b1;
      else       m_solto = 1'b1;
    end
  endtask

  task automatic tick(input logic b, input logic r);
    @(negedge clk);
    botao = b;
    reset = r;
    if (!r) model_reset();
    @(posedge clk);
    if (r) model_edge(b);
    #1;
    if (click) click_cnt++;
    if (solto) solto_cnt++;
    check("model", {click, solto, nivel}, {m_click, m_solto, m_niv});
  endtask

  task automatic hold(input string name, input logic b, input int n,
                      input int click_at, input int solto_at, input logic niv0);
    logic nv;
    nv = niv0;
    for (int i = 0; i < n; i++) begin
      tick(b, 1'b1);
      if (i == click_at) nv = 1'b1;
      if (i == solto_at) nv = 1'b0;
      check(name, {click, solto, nivel}, {i == click_at, i == solto_at, nv});
    end
  endtask

  task automatic add(input logic b, input logic r, input logic c, input logic s,
                     input logic n, input int count);
    vec_t v;
    v.b = b; v.r = r; v.c = c; v.s = s; v.n = n;
    repeat (count) vecs.push_back(v);
  endtask

  initial begin
    int c0, s0;
    logic [2:0] contagem;

    model_reset();
    // reset with pin idle, then idle after reset
    add(1, 0, 0, 0, 0, 3);
    add(1, 1, 0, 0, 0, 3);
    // clean press: click after the 6th edge, level rises with it
    add(0, 1, 0, 0, 0, 5);
    add(0, 1, 1, 0, 1, 1);
    add(0, 1, 0, 0, 1, 2);
    // clean release
    add(1, 1, 0, 0, 1, 5);
    add(1, 1, 0, 1, 0, 1);
    add(1, 1, 0, 0, 0, 2);

    foreach (vecs[i]) begin
      tick(vecs[i].b, vecs[i].r);
      check($sformatf("vec%0d", i), {click, solto, nivel}, {vecs[i].c, vecs[i].s, vecs[i].n});
    end

    // bounce: 2-cycle toggles, then settle pressed
    hold("bounce", 0, 2, -1, -1, 0);
    hold("bounce", 1, 2, -1, -1, 0);
    hold("bounce", 0, 2, -1, -1, 0);
    hold("bounce", 1, 2, -1, -1, 0);
    hold("bounce_settle", 0, 10, 5, -1, 0);

    // release glitch while pressed
    hold("rel_glitch", 1, 2, -1, -1, 1);
    hold("rel_glitch_back", 0, 8, -1, -1, 1);
    hold("release", 1, 8, -1, 5, 1);

    // reset in the middle of PRESS_WAIT, button kept down
    hold("pw_pre_reset", 0, 4, -1, -1, 0);
    tick(0, 0);
    check("mid_reset", {click, solto, nivel}, 3'b000);
    tick(0, 0);
    check("mid_reset", {click, solto, nivel}, 3'b000);
    hold("post_reset_press", 0, 8, 5, -1, 0);
    hold("post_reset_release", 1, 8, -1, 5, 1);

    // reset while fully pressed drops the level at once
    hold("pre_reset_press", 0, 8, 5, -1, 0);
    tick(0, 0);
    check("reset_pressed", {click, solto, nivel}, 3'b000);
    hold("held_through_reset", 0, 8, 5, -1, 0);
    hold("held_release", 1, 8, -1, 5, 1);

    // eight clean press/release cycles
    c0 = click_cnt;
    s0 = solto_cnt;
    repeat (8) begin
      hold("cycle_press", 0, 7, 5, -1, 0);
      hold("cycle_release", 1, 7, -1, 5, 1);
    end
    tests++;
    if (click_cnt - c0 != 8) begin
      fails++;
      $display("FAIL click_count: got %0d required 8", click_cnt - c0);
    end
    tests++;
    if (solto_cnt - s0 != 8) begin
      fails++;
      $display("FAIL solto_count: got %0d required 8", solto_cnt - s0);
    end
    contagem = 3'(click_cnt - c0);
    tests++;
    if (contagem != 3'd0) begin
      fails++;
      $display("FAIL contagem: got %0d required 0", contagem);
    end

    // random runs of 1..7 cycles with rare resets, checked against the reference
    for (int k = 0; k < 600; k++) begin
      logic b;
      int   len;
      b   = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 7));
      for (int j = 0; j < len; j++) begin
        tick(b, 1'($urandom_range(0, 299) != 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
